fwd_hazard_unit: RTL and testbench

Pipeline control block for the 16-bit five-stage datapath that drives the operand-forwarding select lines (ForwardA/ForwardB) consumed by the EX-stage operand muxes. It also generates the load-use stall and bubble controls. It tracks the destination register, write-enable and load flag of every in-flight instruction in internal shadow pipeline registers. It compares that state against the source registers of the instruction in ID and emits registered forward selects that are valid during that instruction's EX cycle.

---
 rtl/fwd_hazard_unit.sv | 138 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard control for the 16-bit five-stage pipeline.
// Shadows rd/regwrite/memread/valid of in-flight instructions and registers EX-stage forward selects.
module fwd_hazard_unit #(
   parameter int RA_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             stall,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_EXM  = 2'b10;
   localparam logic [1:0] FWD_MWB  = 2'b01;

   logic [RA_W-1:0]  ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
   logic             ex_regwrite_q, ex_regwrite_d;
   logic             mem_regwrite_q, mem_regwrite_d;
   logic             wb_regwrite_q, wb_regwrite_d;
   logic             ex_memread_q, ex_memread_d;
   logic             mem_memread_q, mem_memread_d;
   logic             wb_memread_q, wb_memread_d;
   logic             ex_valid_q, ex_valid_d;
   logic             mem_valid_q, mem_valid_d;
   logic             wb_valid_q, wb_valid_d;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic ex_prod, mem_prod;
   logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
   logic stall_c, bubble_c;

   always_comb begin
      ex_prod  = ex_valid_q & ex_regwrite_q & (ex_rd_q != '0);
      mem_prod = mem_valid_q & mem_regwrite_q & (mem_rd_q != '0);
      ex_hit1  = ex_prod & id_use_rs1 & (ex_rd_q == id_rs1);
      ex_hit2  = ex_prod & id_use_rs2 & (ex_rd_q == id_rs2);
      mem_hit1 = mem_prod & id_use_rs1 & (mem_rd_q == id_rs1);
      mem_hit2 = mem_prod & id_use_rs2 & (mem_rd_q == id_rs2);
      // A load still in EX cannot supply its data yet; flush takes precedence over the stall.
      stall_c  = id_valid & ~flush & ex_memread_q & (ex_hit1 | ex_hit2);
      bubble_c = stall_c | flush;
   end

   always_comb begin
      fwd_a_d = FWD_NONE;
      fwd_b_d = FWD_NONE;
      if (!bubble_c) begin
         if (ex_hit1)       fwd_a_d = FWD_EXM;
         else if (mem_hit1) fwd_a_d = FWD_MWB;
         if (ex_hit2)       fwd_b_d = FWD_EXM;
         else if (mem_hit2) fwd_b_d = FWD_MWB;
      end

      ex_rd_d       = id_rd;
      ex_regwrite_d = id_regwrite;
      ex_memread_d  = id_memread;
      ex_valid_d    = id_valid;
      if (bubble_c) begin
         ex_regwrite_d = 1'b0;
         ex_memread_d  = 1'b0;
         ex_valid_d    = 1'b0;
      end

      mem_rd_d       = ex_rd_q;
      mem_regwrite_d = ex_regwrite_q;
      mem_memread_d  = ex_memread_q;
      mem_valid_d    = ex_valid_q;
      wb_rd_d        = mem_rd_q;
      wb_regwrite_d  = mem_regwrite_q;
      wb_memread_d   = mem_memread_q;
      wb_valid_d     = mem_valid_q;

      stall_cnt_d = stall_cnt_q;
      if (stall_c && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rd_q        <= '0;
         ex_regwrite_q  <= 1'b0;
         ex_memread_q   <= 1'b0;
         ex_valid_q     <= 1'b0;
         mem_rd_q       <= '0;
         mem_regwrite_q <= 1'b0;
         mem_memread_q  <= 1'b0;
         mem_valid_q    <= 1'b0;
         wb_rd_q        <= '0;
         wb_regwrite_q  <= 1'b0;
         wb_memread_q   <= 1'b0;
         wb_valid_q     <= 1'b0;
         fwd_a_q        <= FWD_NONE;
         fwd_b_q        <= FWD_NONE;
         stall_cnt_q    <= '0;
      end else begin
         ex_rd_q        <= ex_rd_d;
         ex_regwrite_q  <= ex_regwrite_d;
         ex_memread_q   <= ex_memread_d;
         ex_valid_q     <= ex_valid_d;
         mem_rd_q       <= mem_rd_d;
         mem_regwrite_q <= mem_regwrite_d;
         mem_memread_q  <= mem_memread_d;
         mem_valid_q    <= mem_valid_d;
         wb_rd_q        <= wb_rd_d;
         wb_regwrite_q  <= wb_regwrite_d;
         wb_memread_q   <= wb_memread_d;
         wb_valid_q     <= wb_valid_d;
         fwd_a_q        <= fwd_a_d;
         fwd_b_q        <= fwd_b_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   // The wb entry is tracked for debug visibility only; the register file bypass covers wb->ID.
   logic unused_wb;
   assign unused_wb = ^{wb_rd_q, wb_regwrite_q, wb_memread_q, wb_valid_q, mem_memread_q};

   assign fwd_a     = fwd_a_q;
   assign fwd_b     = fwd_b_q;
   assign stall     = stall_c;
   assign bubble    = bubble_c;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit; CNT_W=2 so counter saturation is reachable.
module tb_fwd_hazard_unit;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic [3:0] id_rs1, id_rs2, id_rd;
   logic       id_use_rs1, id_use_rs2, id_regwrite, id_memread, flush;
   logic [1:0] fwd_a, fwd_b;
   logic       stall, bubble;
   logic [1:0] stall_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   fwd_hazard_unit #(.RA_W(4), .CNT_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .id_rd      (id_rd),
      .id_regwrite(id_regwrite),
      .id_memread (id_memread),
      .flush      (flush),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b),
      .stall      (stall),
      .bubble     (bubble),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                                input logic u1, input logic u2, input logic [3:0] rd,
                                input logic rw, input logic mr, input logic fl);
      id_valid    = v;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_use_rs1  = u1;
      id_use_rs2  = u2;
      id_rd       = rd;
      id_regwrite = rw;
      id_memread  = mr;
      flush       = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #10;
      checkOutput("rst_fwd_a", fwd_a, 2'b00);
      checkOutput("rst_fwd_b", fwd_b, 2'b00);
      checkOutput("rst_stall", stall, 1'b0);
      checkOutput("rst_bubble", bubble, 1'b0);
      checkOutput("rst_cnt", stall_cnt, 2'd0);
      rst_n = 1'b1;
      tick();

      // Distance 1: ADD R3 ; SUB R4,R1,R3
      applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0);
      tick();
      checkOutput("add_fwd_a", fwd_a, 2'b00);
      applyStimulus(1, 1, 3, 1, 1, 4, 1, 0, 0);
      checkOutput("d1_stall", stall, 1'b0);
      tick();
      checkOutput("d1_fwd_a", fwd_a, 2'b00);
      checkOutput("d1_fwd_b", fwd_b, 2'b10);
      nop(); nop();

      // Distance 2: ADD R3 ; NOP ; OR R5,R3,R4
      applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0);
      tick();
      nop();
      applyStimulus(1, 3, 4, 1, 1, 5, 1, 0, 0);
      tick();
      checkOutput("d2_fwd_a", fwd_a, 2'b01);
      checkOutput("d2_fwd_b", fwd_b, 2'b00);
      nop(); nop();

      // Priority: ADD R3 ; ADD R3 ; AND R6,R3,R2
      applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0);
      tick();
      applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0);
      tick();
      applyStimulus(1, 3, 2, 1, 1, 6, 1, 0, 0);
      tick();
      checkOutput("prio_fwd_a", fwd_a, 2'b10);
      checkOutput("prio_fwd_b", fwd_b, 2'b00);
      nop(); nop();

      // Load-use: LW R5 ; ADD R6,R5,R5
      applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0);
      tick();
      applyStimulus(1, 5, 5, 1, 1, 6, 1, 0, 0);
      checkOutput("lu_stall", stall, 1'b1);
      checkOutput("lu_bubble", bubble, 1'b1);
      tick();
      checkOutput("lu_bub_fwd_a", fwd_a, 2'b00);
      checkOutput("lu_bub_fwd_b", fwd_b, 2'b00);
      checkOutput("lu_cnt", stall_cnt, 2'd1);
      checkOutput("lu_stall_rel", stall, 1'b0);
      checkOutput("lu_bubble_rel", bubble, 1'b0);
      tick();
      checkOutput("lu_fwd_a", fwd_a, 2'b01);
      checkOutput("lu_fwd_b", fwd_b, 2'b01);
      checkOutput("lu_cnt_hold", stall_cnt, 2'd1);
      nop(); nop();

      // R0 producer never forwards
      applyStimulus(1, 1, 2, 1, 1, 0, 1, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 1, 1, 7, 1, 0, 0);
      tick();
      checkOutput("r0_fwd_a", fwd_a, 2'b00);
      checkOutput("r0_fwd_b", fwd_b, 2'b00);
      nop(); nop();

      // Unused operand matching a load does not stall
      applyStimulus(1, 1, 0, 1, 0, 2, 1, 1, 0);
      tick();
      applyStimulus(1, 2, 7, 0, 1, 8, 1, 0, 0);
      checkOutput("unused_stall", stall, 1'b0);
      tick();
      checkOutput("unused_fwd_a", fwd_a, 2'b00);
      nop(); nop();

      // Flush overrides load-use stall
      applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0);
      tick();
      applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 1);
      checkOutput("fl_stall", stall, 1'b0);
      checkOutput("fl_bubble", bubble, 1'b1);
      tick();
      checkOutput("fl_fwd_a", fwd_a, 2'b00);
      checkOutput("fl_fwd_b", fwd_b, 2'b00);
      checkOutput("fl_cnt", stall_cnt, 2'd1);
      applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0);
      checkOutput("fl_next_stall", stall, 1'b0);
      tick();
      checkOutput("fl_next_fwd_a", fwd_a, 2'b01);
      nop(); nop();

      // Reset mid-stream discards in-flight producers
      applyStimulus(1, 1, 2, 1, 1, 9, 1, 0, 0);
      tick();
      applyStimulus(1, 9, 0, 1, 0, 7, 1, 1, 0);
      tick();
      checkOutput("pre_rst_fwd_a", fwd_a, 2'b10);
      applyStimulus(1, 7, 0, 1, 0, 10, 1, 0, 0);
      checkOutput("pre_rst_stall", stall, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_fwd_a", fwd_a, 2'b00);
      checkOutput("mid_rst_fwd_b", fwd_b, 2'b00);
      checkOutput("mid_rst_stall", stall, 1'b0);
      checkOutput("mid_rst_cnt", stall_cnt, 2'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_stall", stall, 1'b0);
      tick();
      checkOutput("post_rst_fwd_a", fwd_a, 2'b00);
      nop(); nop();

      // Counter saturates at all-ones
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1, 1, 0, 1, 0, 5, 1, 1, 0);
         tick();
         applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0);
         checkOutput("sat_stall", stall, 1'b1);
         tick();
         tick();
         checkOutput("sat_cnt", stall_cnt, (i > 3) ? 16'd3 : 16'(i));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
